// File: rtl/if_irq_fetch_if.sv
// Fetch-stage bus: interrupt inputs, execute-side redirects, instruction memory
// handshake and the fetch outputs towards decode.
interface if_irq_fetch_if #(
  parameter int unsigned CPU_WIDTH = 16,
  parameter int unsigned IRQ_NUM   = 8
);
  logic [IRQ_NUM-1:0]   irq;
  logic [IRQ_NUM-1:0]   irq_mask;
  logic                 gie;
  logic                 stall;
  logic                 PCSel;
  logic [CPU_WIDTH-1:0] branch_pc;
  logic                 mret;
  logic                 inst_valid;
  logic [CPU_WIDTH-1:0] inst_data;
  logic [CPU_WIDTH-1:0] inst_addr;
  logic [CPU_WIDTH-1:0] inst_out;
  logic [CPU_WIDTH-1:0] epc;
  logic [IRQ_NUM-1:0]   irq_ack;
  logic                 in_isr;

  // Fetch stage side
  modport slave (
    input  irq, irq_mask, gie, stall, PCSel, branch_pc, mret, inst_valid, inst_data,
    output inst_addr, inst_out, epc, irq_ack, in_isr
  );

  // Environment side (memory / execute / interrupt controller)
  modport master (
    output irq, irq_mask, gie, stall, PCSel, branch_pc, mret, inst_valid, inst_data,
    input  inst_addr, inst_out, epc, irq_ack, in_isr
  );
endinterface

// File: rtl/if_irq_fetch.sv
// Instruction fetch / PC generation with prioritised, maskable vectored
// interrupts, EPC save and return-from-interrupt.
module if_irq_fetch #(
  parameter int unsigned CPU_WIDTH  = 16,
  parameter int unsigned IRQ_NUM    = 8,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned VEC_BASE   = 0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  if_irq_fetch_if.slave  bus
);

  typedef enum logic {RUN, ISR} state_t;

  state_t               r_state;
  logic [CPU_WIDTH-1:0] r_pc;
  logic [CPU_WIDTH-1:0] r_epc;
  logic [CPU_WIDTH-1:0] r_inst_out;
  logic [IRQ_NUM-1:0]   r_irq_ack;

  logic [CPU_WIDTH-1:0] w_seq_pc;
  logic [CPU_WIDTH-1:0] w_nrm_pc;
  logic [CPU_WIDTH-1:0] w_vec_pc;
  logic [IRQ_NUM-1:0]   w_pend;
  logic [IRQ_NUM-1:0]   w_onehot;
  logic [3:0]           w_idx;
  logic                 w_take;

  always_comb begin
    w_seq_pc = bus.inst_valid ? r_pc + CPU_WIDTH'(1) : r_pc;
    w_nrm_pc = bus.PCSel ? bus.branch_pc : w_seq_pc;
    w_pend   = bus.irq & bus.irq_mask;
    w_idx    = '0;
    w_onehot = '0;
    // Scan from the top so the lowest pending index is the last (winning) write
    for (int unsigned i = 0; i < IRQ_NUM; i++) begin
      if (w_pend[IRQ_NUM-1-i]) begin
        w_idx                  = 4'(IRQ_NUM-1-i);
        w_onehot               = '0;
        w_onehot[IRQ_NUM-1-i]  = 1'b1;
      end
    end
    w_vec_pc = CPU_WIDTH'(VEC_BASE + 32'(w_idx) * VEC_STRIDE);
    w_take   = (r_state == RUN) && bus.gie && (|w_pend) && !bus.stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= CPU_WIDTH'(RESET_PC);
      r_epc      <= '0;
      r_inst_out <= '0;
      r_irq_ack  <= '0;
    end else if (bus.stall) begin
      r_irq_ack  <= '0;
    end else begin
      r_inst_out <= bus.inst_data;
      r_irq_ack  <= '0;
      if (bus.mret && r_state == ISR) begin
        r_pc    <= r_epc;
        r_state <= RUN;
      end else if (w_take) begin
        r_epc     <= w_nrm_pc;
        r_pc      <= w_vec_pc;
        r_irq_ack <= w_onehot;
        r_state   <= ISR;
      end else begin
        r_pc <= w_nrm_pc;
      end
    end
  end

  assign bus.inst_addr = r_pc;
  assign bus.inst_out  = r_inst_out;
  assign bus.epc       = r_epc;
  assign bus.irq_ack   = r_irq_ack;
  assign bus.in_isr    = (r_state == ISR);

endmodule

// File: doc/if_irq_fetch.md
Name: if_irq_fetch

Overview:
- Parametrised instruction-fetch / PC-generation stage for the 16-bit core.
- Holds the PC and drives the instruction address. Fetches sequentially or redirects on a branch.
- Handles prioritised, maskable vectored interrupts. Saves a return PC (EPC) and restores it on return-from-interrupt.
- Sits between the instruction memory and decode; branch and return requests come from execute.

Parameters:
- CPU_WIDTH, 16, PC / instruction width.
- IRQ_NUM, 8, number of interrupt lines (1..16).
- RESET_PC, 0, PC value loaded on reset.
- VEC_BASE, 0, address of the vector for irq[0].
- VEC_STRIDE, 4, address step between consecutive vectors.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  IRQ_NUM  level-sensitive interrupt requests.
- irq_mask  in  IRQ_NUM  per-line enable; 1 = enabled.
- gie  in  1  global interrupt enable.
- stall  in  1  freeze the fetch stage.
- PCSel  in  1  take branch_pc.
- branch_pc  in  CPU_WIDTH  branch target.
- mret  in  1  return from interrupt.
- inst_valid  in  1  fetched word valid; when 0, PC holds.
- inst_data  in  CPU_WIDTH  fetched instruction; forwarded, not interpreted.
- inst_addr  out  CPU_WIDTH  current PC.
- inst_out  out  CPU_WIDTH  registered inst_data to decode.
- epc  out  CPU_WIDTH  saved return PC.
- irq_ack  out  IRQ_NUM  one-hot, one-cycle pulse for the taken line.
- in_isr  out  1  high while servicing an interrupt.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, so inst_addr = RESET_PC.
  - inst_out = 0, epc = 0, irq_ack = 0, in_isr = 0, state = RUN.
- States:
  - RUN: no interrupt being serviced.
  - ISR: interrupt being serviced; in_isr = 1.
- Sequential next PC (seq_pc): pc + 1 if inst_valid, else pc. Modulo 2^CPU_WIDTH, so 0xFFFF wraps to 0x0000.
- Normal next PC (nrm_pc): branch_pc if PCSel, else seq_pc.
- Pending vector: pend = irq & irq_mask. Lowest index has highest priority; idx = lowest set bit of pend.
- Take condition: state == RUN, gie = 1, pend != 0, stall = 0.
- Per-edge priority, first matching case wins:
  1. stall = 1: all registers hold; irq_ack = 0; mret and PCSel are ignored, not queued.
  2. mret = 1 and state == ISR: pc <= epc, state <= RUN. No interrupt may be taken in this cycle; a pending one is taken on the next eligible edge.
  3. Take condition true:
     - epc <= nrm_pc (a same-cycle branch target is preserved, not lost).
     - pc <= VEC_BASE + idx*VEC_STRIDE, truncated to CPU_WIDTH.
     - irq_ack[idx] <= 1 for exactly one cycle; state <= ISR.
  4. Otherwise: pc <= nrm_pc.
- mret in RUN is ignored; PC advances per case 4.
- In ISR, further interrupts are held off (no nesting). Requests remain pending as long as the level is held.
- irq_ack is registered: it is high in the cycle after the take edge, together with the vector on inst_addr.
- inst_out <= inst_data on every non-stall edge; it holds while stall = 1.
- Latency: redirect, vector and return each take effect on inst_addr one cycle after the request edge.
- rst_n asserted mid-ISR returns immediately to the reset values; epc is lost.

Test Plan:
- Reset, then inst_valid = 1 for 4 cycles -> inst_addr 0, 1, 2, 3, 4; in_isr = 0.
- pc = 0x0010, PCSel = 1, branch_pc = 0x0040 -> inst_addr = 0x0040 next cycle; inst_valid = 0 for 2 cycles -> addr holds at 0x0040.
- pc = 0x0020, irq = 0x06, mask = 0xFF, gie = 1 -> inst_addr = VEC_BASE + 1*4 = 0x0004; irq_ack = 0x02 for one cycle; epc = 0x0021; in_isr = 1.
- In ISR, assert irq = 0x01 -> not taken. Then mret -> inst_addr = 0x0021, in_isr = 0. Next cycle irq0 taken -> inst_addr = 0x0000, irq_ack = 0x01.
- irq0 and PCSel (branch_pc = 0x0100) in the same cycle -> vector 0x0000, epc = 0x0100. Same stimulus with stall = 1 -> pc and epc hold, irq_ack = 0.
- irq = 0x08 with mask = 0xF7 or gie = 0 -> no take. pc = 0xFFFF with inst_valid = 1 -> wraps to 0x0000. rst_n pulsed while in_isr = 1 -> in_isr = 0, inst_addr = RESET_PC.
